cdb_broadcaster: RTL
====================

CDB_BROADCASTER -- requirements
Module: cdb_broadcaster

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of functional-unit completion sources.
REQ-002 SHALL have parameter BUF_DEPTH, default 2: per-source completion buffer depth, a power of two and at least 2.
REQ-003 SHALL have the port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have the port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-005 SHALL have the port flush, input, 1 bit: synchronous squash of all pending completions.
REQ-006 SHALL have the port fu_valid, input, NUM_SRC bits: per-source completion offer.
REQ-007 SHALL have the port fu_rob_tag, input, NUM_SRC x (`ROB_TAG_LEN+1) bits: ROB tag of each completing instruction.
REQ-008 SHALL have the port fu_value, input, NUM_SRC x 32 bits: result value of each completing instruction.
REQ-009 SHALL have the port fu_ready, output, NUM_SRC bits: the buffer for that source can accept a completion.
REQ-010 SHALL have the port cdb, output, CDB_DATA (valid, rob_tag, value): the registered broadcast consumed by reservation stations and the ROB.

Function
REQ-011 SHALL accept a completion from source i at a rising edge when fu_valid[i] and fu_ready[i] are both high and flush is low.
REQ-012 SHALL drive fu_ready[i] high exactly when buffer i is not full, with no combinational path from fu_valid or from arbitration.
REQ-013 SHALL store each source's completions in a FIFO of BUF_DEPTH entries and deliver them in acceptance order.
REQ-014 SHALL pick one winner each cycle among sources with a non-empty buffer, round-robin, starting at pointer rr_ptr.
REQ-015 SHALL, at each edge with a winner, pop the winner's head into the cdb register with cdb.valid=1 and set rr_ptr to (winner+1) mod NUM_SRC.
REQ-016 SHALL, at each edge with no winner, load cdb.valid=0 and leave cdb.rob_tag, cdb.value and rr_ptr unchanged.
REQ-017 SHALL broadcast each accepted completion exactly once, so cdb.valid is high for exactly one cycle per completion.
REQ-018 SHALL make an accepted completion visible on cdb no earlier than one cycle after acceptance (non-bypass latency of one cycle).
REQ-019 SHALL allow a push and a pop on the same buffer at the same edge, leaving occupancy unchanged, including when the buffer is full (fu_ready was high the previous cycle only if not full).
REQ-020 SHALL, when flush is high at an edge, empty all buffers, clear cdb.valid, reset rr_ptr to 0 and ignore any concurrent fu_valid; flush takes priority over push and pop.
REQ-021 SHALL wrap buffer pointers modulo BUF_DEPTH and SHALL distinguish full from empty with a count or an extra pointer bit.

Reset
REQ-022 SHALL, while reset is low and independent of clk, force cdb.valid=0, cdb.rob_tag=0, cdb.value=0, every buffer empty, rr_ptr=0 and fu_ready all high once released.
REQ-023 SHALL discard all in-flight completions on reset assertion mid-operation, with no broadcast of any of them after release.

Configuration
REQ-024 SHALL implement the bypass feature only when macro CDB_BYPASS_EN is defined.
REQ-025 SHALL, with CDB_BYPASS_EN defined, let a source whose buffer is empty and whose fu_valid is high join arbitration in the same cycle; if it wins, the completion loads directly into cdb at the accepting edge (zero-cycle latency) and is not written to the buffer.
REQ-026 SHALL, without CDB_BYPASS_EN, make arbitration consider buffered entries only, per REQ-018.

Structure
REQ-027 SHALL take CDB_DATA and `ROB_TAG_LEN from the shared sys_defs package/header, and SHALL add the FU_COMPLETION typedef (rob_tag, value) there.
REQ-028 SHALL instantiate one sub-module, cdb_src_fifo (parameterised by BUF_DEPTH), NUM_SRC times.

Verification
REQ-029 SHALL check single completion: source 1 offers tag=3, value=0x55 for one cycle -> exactly one cycle later cdb shows valid=1, rob_tag=3, value=0x55 for one cycle (same cycle when CDB_BYPASS_EN is defined).
REQ-030 SHALL check contention: sources 0-3 offer tags 1,2,3,4 at the same edge with rr_ptr=0 -> cdb broadcasts tags 1,2,3,4 on four consecutive cycles.
REQ-031 SHALL check fairness: source 0 offers continuously and source 2 offers tag=7 once -> tag 7 appears within NUM_SRC cycles and source 0 is not starved.
REQ-032 SHALL check backpressure: source 1 offers 3 completions back-to-back while source 0 holds its slot -> fu_ready[1] drops after 2 accepted, and all 3 tags are broadcast in order with none lost.
REQ-033 SHALL check flush: 3 entries pending and flush pulsed -> no cdb.valid afterwards, fu_ready all high, and a new offer tag=9 is broadcast normally.
REQ-034 SHALL check reset: reset driven low mid-broadcast between clock edges -> cdb.valid falls to 0 immediately, and after release nothing is broadcast until new offers arrive.

Source files
------------

// File: rtl/sys_defs_pkg.sv
// Shared core definitions: ROB tag width, the CDB broadcast record and the
// functional-unit completion record used by the completion path.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 4
`endif

package sys_defs;

  localparam int ROB_TAG_W = `ROB_TAG_LEN + 1;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [31:0]          value;
  } CDB_DATA;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [31:0]          value;
  } FU_COMPLETION;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source completion FIFO: BUF_DEPTH entries (power of two), occupancy
// counter separates full from empty, flush empties it synchronously.
module cdb_src_fifo
  import sys_defs::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  FU_COMPLETION din,
  output FU_COMPLETION dout,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  FU_COMPLETION     mem_r [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Storage, pointers and occupancy; pointers wrap naturally at BUF_DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == CNT_W'(BUF_DEPTH));
  assign empty = (count_r == CNT_W'(0));

endmodule

// File: rtl/cdb_broadcaster.sv
// Common data bus broadcaster: buffers FU completions per source and broadcasts
// one per cycle, round-robin. Define CDB_BYPASS_EN for zero-latency bypass.
module cdb_broadcaster
  import sys_defs::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int BUF_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [NUM_SRC-1:0]                 fu_valid,
  input  logic [NUM_SRC-1:0][ROB_TAG_W-1:0]  fu_rob_tag,
  input  logic [NUM_SRC-1:0][31:0]           fu_value,
  output logic [NUM_SRC-1:0]                 fu_ready,
  output CDB_DATA                            cdb
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] full_s;
  logic [NUM_SRC-1:0] empty_s;
  logic [NUM_SRC-1:0] accept_s;
  logic [NUM_SRC-1:0] req_s;
  logic [NUM_SRC-1:0] push_s;
  logic [NUM_SRC-1:0] pop_s;
  FU_COMPLETION       head_s [NUM_SRC];
  FU_COMPLETION       win_data_s;
  logic               win_valid_s;
  logic [SRC_W-1:0]   win_idx_s;
  logic [SRC_W-1:0]   rr_nxt_s;
  logic [SRC_W-1:0]   rr_ptr_r;
  int                 scan_idx_s;
  CDB_DATA            cdb_r;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    FU_COMPLETION din_s;
    assign din_s = {fu_rob_tag[g], fu_value[g]};

    cdb_src_fifo #(
      .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push_s[g]),
      .pop   (pop_s[g]),
      .din   (din_s),
      .dout  (head_s[g]),
      .full  (full_s[g]),
      .empty (empty_s[g])
    );

    // Ready depends only on buffer state, never on this cycle's offers.
    assign fu_ready[g] = ~full_s[g];
  end

  assign accept_s = fu_valid & fu_ready & {NUM_SRC{~flush}};

`ifdef CDB_BYPASS_EN
  assign req_s = ~empty_s | accept_s;
`else
  assign req_s = ~empty_s;
`endif

  // Round-robin scan starting at rr_ptr_r; first requester wins.
  always_comb begin
    win_valid_s = 1'b0;
    win_idx_s   = SRC_W'(0);
    scan_idx_s  = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx_s = int'(rr_ptr_r) + k;
      if (scan_idx_s >= NUM_SRC) begin
        scan_idx_s = scan_idx_s - NUM_SRC;
      end else begin
        scan_idx_s = scan_idx_s;
      end
      if (!win_valid_s && req_s[scan_idx_s]) begin
        win_valid_s = 1'b1;
        win_idx_s   = SRC_W'(scan_idx_s);
      end else begin
        win_idx_s   = win_idx_s;
      end
    end
  end

  // Winner data plus per-source push/pop strobes; a bypassed winner skips its buffer.
  always_comb begin
    win_data_s = head_s[win_idx_s];
    push_s     = accept_s;
    pop_s      = {NUM_SRC{1'b0}};
    if (win_valid_s && !flush) begin
`ifdef CDB_BYPASS_EN
      if (empty_s[win_idx_s]) begin
        win_data_s          = {fu_rob_tag[win_idx_s], fu_value[win_idx_s]};
        push_s[win_idx_s]   = 1'b0;
      end else begin
        pop_s[win_idx_s]    = 1'b1;
      end
`else
      pop_s[win_idx_s] = 1'b1;
`endif
    end else begin
      pop_s = {NUM_SRC{1'b0}};
    end
  end

  // Pointer advances to the source after the winner, wrapping at NUM_SRC.
  always_comb begin
    if (int'(win_idx_s) == NUM_SRC - 1) begin
      rr_nxt_s = SRC_W'(0);
    end else begin
      rr_nxt_s = win_idx_s + SRC_W'(1);
    end
  end

  // Broadcast register and arbitration pointer; flush clears valid but keeps payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb_r    <= '0;
      rr_ptr_r <= SRC_W'(0);
    end else if (flush) begin
      cdb_r.valid <= 1'b0;
      rr_ptr_r    <= SRC_W'(0);
    end else if (win_valid_s) begin
      cdb_r    <= {1'b1, win_data_s};
      rr_ptr_r <= rr_nxt_s;
    end else begin
      cdb_r.valid <= 1'b0;
    end
  end

  assign cdb = cdb_r;

endmodule
